// File: rtl/tc_sram_banked_pkg.sv
// Shared types and helpers for the banked SRAM: bank-field width,
// read-pipeline metadata and the round-robin pointer update.
package tc_sram_banked_pkg;

  localparam int unsigned PortIdxW = 8;

  // Data travels in a parallel array so this struct stays width-independent.
  typedef struct packed {
    logic                valid;
    logic [PortIdxW-1:0] port;
  } pipe_meta_t;

  function automatic int unsigned bank_sel_w(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_ports);
    return (idx + 1 >= num_ports) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tc_sram_bank_rr_arb.sv
// Per-bank round-robin arbiter; grant is combinational, the pointer advances
// to one past the granted port and holds when nothing is granted.
module tc_sram_bank_rr_arb
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                gnt_vld_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] cidx;
  int unsigned         cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    ptr_d     = ptr_q;
    cand      = 0;
    cidx      = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NumPorts) cand = cand - NumPorts;
      cidx = IdxWidth'(cand);
      if (!gnt_vld_o && req_i[cidx]) begin
        gnt_vld_o   = 1'b1;
        gnt_o[cidx] = 1'b1;
        gnt_idx_o   = cidx;
        ptr_d       = IdxWidth'(rr_next(32'(cidx), NumPorts));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));

endmodule

// File: rtl/tc_sram_banked.sv
// Multi-port SRAM over word-interleaved single-port banks with per-bank
// round-robin arbitration and a Latency-deep read return pipeline.
module tc_sram_banked
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0]                 gnt_o,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  localparam int unsigned BankBits     = (NumBanks > 1) ? $clog2(NumBanks) : 0;
  localparam int unsigned BankSelW     = bank_sel_w(NumBanks);
  localparam int unsigned RowW         = (AddrWidth > BankBits) ? AddrWidth - BankBits : 1;
  localparam int unsigned WordsPerBank = NumWords / NumBanks;
  localparam int unsigned IdxW         = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [NumPorts-1:0][BankSelW-1:0]  port_bank;
  logic [NumPorts-1:0][RowW-1:0]      port_row;
  logic [NumBanks-1:0][NumPorts-1:0]  bank_req, bank_gnt;
  logic [NumBanks-1:0][IdxW-1:0]      bank_idx;
  logic [NumBanks-1:0]                bank_vld;
  logic [NumBanks-1:0][DataWidth-1:0] bank_rdata, tail_data;
  pipe_meta_t [NumBanks-1:0]          launch_meta, tail_meta;
  logic [NumPorts-1:0]                rvalid_d, rvalid_q;
  logic [NumPorts-1:0][DataWidth-1:0] rdata_d, rdata_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_decode
    if (NumBanks > 1) begin : g_multi
      assign port_bank[p] = addr_i[p][BankSelW-1:0];
      assign port_row[p]  = RowW'(addr_i[p] >> BankBits);
    end else begin : g_single
      assign port_bank[p] = '0;
      assign port_row[p]  = addr_i[p];
    end
  end

  always_comb begin
    bank_req = '0;
    for (int unsigned b = 0; b < NumBanks; b++)
      for (int unsigned p = 0; p < NumPorts; p++)
        bank_req[b][p] = req_i[p] && (32'(port_bank[p]) == b);
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned b = 0; b < NumBanks; b++) gnt_o = gnt_o | bank_gnt[b];
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [DataWidth-1:0] mem_q [WordsPerBank];
    logic [RowW-1:0]      row;
    logic [DataWidth-1:0] wmask;

    tc_sram_bank_rr_arb #(
      .NumPorts (NumPorts),
      .IdxWidth (IdxW)
    ) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (bank_req[b]),
      .gnt_o     (bank_gnt[b]),
      .gnt_idx_o (bank_idx[b]),
      .gnt_vld_o (bank_vld[b])
    );

    assign row = port_row[bank_idx[b]];

    always_comb begin
      wmask = '0;
      for (int unsigned j = 0; j < DataWidth; j++) wmask[j] = be_i[bank_idx[b]][j / ByteWidth];
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
      if (bank_vld[b] && we_i[bank_idx[b]])
        mem_q[row] <= (mem_q[row] & ~wmask) | (wdata_i[bank_idx[b]] & wmask);
    end

    assign bank_rdata[b]  = mem_q[row];
    assign launch_meta[b] = '{valid: bank_vld[b] && !we_i[bank_idx[b]],
                              port:  PortIdxW'(bank_idx[b])};
  end

  // The output register supplies the final cycle, so Latency-1 stages sit in between.
  if (Latency > 1) begin : g_pipe
    pipe_meta_t [Latency-2:0][NumBanks-1:0]                meta_q;
    logic       [Latency-2:0][NumBanks-1:0][DataWidth-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        meta_q <= '0;
        data_q <= '0;
      end else begin
        meta_q[0] <= launch_meta;
        data_q[0] <= bank_rdata;
        for (int unsigned s = 1; s < Latency - 1; s++) begin
          meta_q[s] <= meta_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
    end

    assign tail_meta = meta_q[Latency-2];
    assign tail_data = data_q[Latency-2];
  end else begin : g_nopipe
    assign tail_meta = launch_meta;
    assign tail_data = bank_rdata;
  end

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int unsigned p = 0; p < NumPorts; p++)
      for (int unsigned b = 0; b < NumBanks; b++)
        if (tail_meta[b].valid && tail_meta[b].port == PortIdxW'(p)) begin
          rvalid_d[p] = 1'b1;
          rdata_d[p]  = tail_data[b];
        end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  a_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i) (gnt_o & ~req_i) == '0);
  a_words_div: assert property (@(posedge clk_i) (NumWords % NumBanks) == 0);
  a_port_fit: assert property (@(posedge clk_i) NumPorts <= (1 << PortIdxW));

  for (genvar p = 0; p < NumPorts; p++) begin : g_range
    a_addr_range: assert property (@(posedge clk_i) disable iff (rst_i)
                                   req_i[p] |-> (32'(addr_i[p]) < NumWords))
      else $warning("tc_sram_banked: port %0d address out of range", p);
  end

endmodule

// File: tb/tb_tc_sram_banked.sv
// Scoreboard bench: one Latency=1 and one Latency=3 instance; grants checked
// at issue, read returns checked by a monitor against queued expectations.
module tb_tc_sram_banked;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;

  logic [3:0]        req_a = '0, we_a = '0, gnt_a, rvalid_a;
  logic [3:0][9:0]   addr_a = '0;
  logic [3:0][63:0]  wdata_a = '0, rdata_a;
  logic [3:0][7:0]   be_a = '0;

  logic [3:0]        req_b = '0, we_b = '0, gnt_b, rvalid_b;
  logic [3:0][9:0]   addr_b = '0;
  logic [3:0][63:0]  wdata_b = '0, rdata_b;
  logic [3:0][7:0]   be_b = '0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[8][$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tc_sram_banked #(.Latency(1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .be_i(be_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a)
  );

  tc_sram_banked #(.Latency(3)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .be_i(be_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b)
  );

  logic        mon_rv;
  logic [63:0] mon_rd;
  exp_t        mon_e;

  always @(negedge clk) begin
    for (int k = 0; k < 8; k++) begin
      mon_rv = (k < 4) ? rvalid_a[k] : rvalid_b[k-4];
      mon_rd = (k < 4) ? rdata_a[k] : rdata_b[k-4];
      if (mon_rv) begin
        checks++;
        if (sb_q[k].size() == 0) begin
          errors++;
          $display("FAIL rvalid_spurious dut%0d port%0d cyc=%0d: got rvalid=1, want 0", k / 4, k % 4, cyc);
        end else begin
          mon_e = sb_q[k].pop_front();
          if (mon_rd !== mon_e.data || cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL rdata dut%0d port%0d: got data=%h cyc=%0d, want data=%h cyc=%0d",
                     k / 4, k % 4, mon_rd, cyc, mon_e.data, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic issue(input int sel, input logic [3:0] req, input logic [3:0] we,
                       input logic [3:0][9:0] addr, input logic [3:0][63:0] wdata,
                       input logic [3:0][7:0] be, input logic [3:0] exp_gnt,
                       input logic [3:0][63:0] exp_rd, input bit push);
    logic [3:0] got;
    int lat;
    @(posedge clk); #1;
    if (sel == 0) begin
      req_a = req; we_a = we; addr_a = addr; wdata_a = wdata; be_a = be;
    end else begin
      req_b = req; we_b = we; addr_b = addr; wdata_b = wdata; be_b = be;
    end
    #2;
    got = (sel == 0) ? gnt_a : gnt_b;
    lat = (sel == 0) ? 1 : 3;
    checks++;
    if (got !== exp_gnt) begin
      errors++;
      $display("FAIL gnt dut%0d cyc=%0d: got %b, want %b", sel, cyc, got, exp_gnt);
    end
    if (push)
      for (int p = 0; p < 4; p++)
        if (exp_gnt[p] && !we[p]) sb_q[sel*4+p].push_back('{data: exp_rd[p], cyc: cyc + lat});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_a = '0;
      req_b = '0;
    end
  endtask

  localparam logic [63:0] F64 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #2;
    chk("reset_gnt_a", 256'(gnt_a), 256'(4'h0));
    chk("reset_rvalid_a", 256'(rvalid_a), 256'(4'h0));
    chk("reset_rdata_a", rdata_a, 256'h0);
    chk("reset_gnt_b", 256'(gnt_b), 256'(4'h0));
    chk("reset_rvalid_b", 256'(rvalid_b), 256'(4'h0));
    chk("reset_rdata_b", rdata_b, 256'h0);

    // Conflict-free writes and read-back, one port per bank.
    issue(0, 4'hF, 4'hF, {10'd3, 10'd2, 10'd1, 10'd0}, {64'hA3, 64'hA2, 64'hA1, 64'hA0},
          {4{8'hFF}}, 4'hF, '0, 1'b0);
    issue(0, 4'hF, 4'h0, {10'd3, 10'd2, 10'd1, 10'd0}, '0, '0, 4'hF,
          {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b1);
    idle(2);
    chk("rdata_hold", rdata_a, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    chk("rvalid_idle", 256'(rvalid_a), 256'(4'h0));

    issue(0, 4'h1, 4'h1, {10'd0, 10'd0, 10'd0, 10'd4}, {64'h0, 64'h0, 64'h0, 64'h44},
          {4{8'hFF}}, 4'h1, '0, 1'b0);

    // Byte enables on address 5 through port 1.
    issue(0, 4'h2, 4'h2, {10'd0, 10'd0, 10'd5, 10'd0}, {64'h0, 64'h0, 64'h1122334455667788, 64'h0},
          {4{8'hFF}}, 4'h2, '0, 1'b0);
    issue(0, 4'h2, 4'h2, {10'd0, 10'd0, 10'd5, 10'd0}, {4{F64}},
          {8'h00, 8'h00, 8'h0F, 8'h00}, 4'h2, '0, 1'b0);
    issue(0, 4'h2, 4'h0, {10'd0, 10'd0, 10'd5, 10'd0}, '0, '0, 4'h2,
          {64'h0, 64'h0, 64'h11223344FFFFFFFF, 64'h0}, 1'b1);
    idle(2);

    // Fresh reset, then every port hammers bank 0.
    @(posedge clk); #1;
    rst_a = 1'b1;
    idle(2);
    rst_a = 1'b0;
    issue(0, 4'hF, 4'h0, {4{10'd4}}, '0, '0, 4'h1, {4{64'h44}}, 1'b1);
    issue(0, 4'hF, 4'h0, {4{10'd4}}, '0, '0, 4'h2, {4{64'h44}}, 1'b1);
    issue(0, 4'hF, 4'h0, {4{10'd4}}, '0, '0, 4'h4, {4{64'h44}}, 1'b1);
    issue(0, 4'hF, 4'h0, {4{10'd4}}, '0, '0, 4'h8, {4{64'h44}}, 1'b1);

    // Two banks each contended by two ports.
    issue(0, 4'hF, 4'h0, {10'd3, 10'd3, 10'd2, 10'd2}, '0, '0, 4'h5,
          {64'hA3, 64'hA3, 64'hA2, 64'hA2}, 1'b1);
    issue(0, 4'hF, 4'h0, {10'd3, 10'd3, 10'd2, 10'd2}, '0, '0, 4'hA,
          {64'hA3, 64'hA3, 64'hA2, 64'hA2}, 1'b1);
    idle(3);

    // Latency=3: fill addresses 8..10, then port 2 reads them back to back.
    issue(1, 4'h7, 4'h7, {10'd0, 10'd10, 10'd9, 10'd8}, {64'h0, 64'hBA, 64'hB9, 64'hB8},
          {4{8'hFF}}, 4'h7, '0, 1'b0);
    issue(1, 4'h4, 4'h0, {10'd0, 10'd8, 10'd0, 10'd0}, '0, '0, 4'h4,
          {64'h0, 64'hB8, 64'h0, 64'h0}, 1'b1);
    issue(1, 4'h4, 4'h0, {10'd0, 10'd9, 10'd0, 10'd0}, '0, '0, 4'h4,
          {64'h0, 64'hB9, 64'h0, 64'h0}, 1'b1);
    issue(1, 4'h4, 4'h0, {10'd0, 10'd10, 10'd0, 10'd0}, '0, '0, 4'h4,
          {64'h0, 64'hBA, 64'h0, 64'h0}, 1'b1);
    idle(5);

    // Read in flight when reset hits must never return.
    issue(1, 4'h4, 4'h0, {10'd0, 10'd8, 10'd0, 10'd0}, '0, '0, 4'h4, '0, 1'b0);
    @(posedge clk); #1;
    req_b = '0;
    rst_b = 1'b1;
    idle(2);
    rst_b = 1'b0;
    issue(1, 4'hF, 4'h0, {4{10'd8}}, '0, '0, 4'h1, {4{64'hB8}}, 1'b1);
    issue(1, 4'hF, 4'h0, {4{10'd8}}, '0, '0, 4'h2, {4{64'hB8}}, 1'b1);
    idle(6);

    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sb_q[k].size() != 0) begin
        errors++;
        $display("FAIL rvalid_missing dut%0d port%0d: got %0d outstanding, want 0", k / 4, k % 4, sb_q[k].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
